// File: rtl/int_to_float.sv
// Multi-cycle 32-bit integer to IEEE-754 single converter (round-to-nearest-even).
// Operand and result move over stb/ack handshakes; normalisation shifts one bit per cycle.
module int_to_float #(
    parameter logic SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_a_stb,
    input  logic [31:0] input_a,
    output logic        input_a_ack,
    output logic        output_z_stb,
    input  logic        output_z_ack,
    output logic [31:0] output_z
);

    typedef enum logic [2:0] {
        GET_A     = 3'd0,
        CONVERT   = 3'd1,
        NORMALISE = 3'd2,
        ROUND     = 3'd3,
        PACK      = 3'd4,
        PUT_Z     = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] a_r, a_s;
    logic [31:0] m_r, m_s;
    logic [7:0]  e_r, e_s;
    logic        sign_r, sign_s;
    logic        zero_r, zero_s;
    logic [23:0] mant_r, mant_s;
    logic [31:0] z_r, z_s;
    logic        ack_r, ack_s;
    logic        stb_r, stb_s;
    logic [24:0] sum_s;

    // Round-to-nearest-even increment decision from lsb, guard, round and sticky bits.
    function automatic logic round_up(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    assign input_a_ack  = ack_r;
    assign output_z_stb = stb_r;
    assign output_z     = z_r;

    // Next-state and next-datapath logic for the conversion sequence.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        m_s     = m_r;
        e_s     = e_r;
        sign_s  = sign_r;
        zero_s  = zero_r;
        mant_s  = mant_r;
        z_s     = z_r;
        ack_s   = ack_r;
        stb_s   = stb_r;
        sum_s   = {1'b0, m_r[31:8]} + 25'd1;
        case (state_r)
            GET_A: begin
                if (!ack_r) begin
                    ack_s = 1'b1;
                end else if (input_a_stb) begin
                    a_s     = input_a;
                    ack_s   = 1'b0;
                    state_s = CONVERT;
                end else begin
                    a_s = a_r;
                end
            end
            CONVERT: begin
                sign_s = (SIGNED != 1'b0) && a_r[31];
                if (sign_s) begin
                    m_s = ~a_r + 32'd1;
                end else begin
                    m_s = a_r;
                end
                e_s    = 8'd31;
                zero_s = (a_r == 32'd0);
                // A zero operand skips straight to the pack slot, which emits +0.
                if (zero_s) begin
                    state_s = PACK;
                end else begin
                    state_s = NORMALISE;
                end
            end
            NORMALISE: begin
                if (!m_r[31]) begin
                    m_s = {m_r[30:0], 1'b0};
                    e_s = e_r - 8'd1;
                end else begin
                    state_s = ROUND;
                end
            end
            ROUND: begin
                mant_s = m_r[31:8];
                if (round_up(m_r[8], m_r[7], m_r[6], |m_r[5:0])) begin
                    if (sum_s[24]) begin
                        mant_s = 24'h800000;
                        e_s    = e_r + 8'd1;
                    end else begin
                        mant_s = sum_s[23:0];
                    end
                end else begin
                    mant_s = m_r[31:8];
                end
                state_s = PACK;
            end
            PACK: begin
                if (zero_r) begin
                    z_s = 32'd0;
                end else begin
                    z_s = {sign_r, e_r + 8'd127, mant_r[22:0]};
                end
                stb_s   = 1'b1;
                state_s = PUT_Z;
            end
            PUT_Z: begin
                if (output_z_ack) begin
                    stb_s   = 1'b0;
                    ack_s   = 1'b1;
                    state_s = GET_A;
                end else begin
                    stb_s = 1'b1;
                end
            end
            default: begin
                state_s = GET_A;
                ack_s   = 1'b0;
                stb_s   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= GET_A;
            a_r     <= 32'd0;
            m_r     <= 32'd0;
            e_r     <= 8'd0;
            sign_r  <= 1'b0;
            zero_r  <= 1'b0;
            mant_r  <= 24'd0;
            z_r     <= 32'd0;
            ack_r   <= 1'b0;
            stb_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            m_r     <= m_s;
            e_r     <= e_s;
            sign_r  <= sign_s;
            zero_r  <= zero_s;
            mant_r  <= mant_s;
            z_r     <= z_s;
            ack_r   <= ack_s;
            stb_r   <= stb_s;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Directed-vector bench for int_to_float: signed and unsigned instances share the input side.
module tb_int_to_float;

    logic        clk;
    logic        rst;
    logic        a_stb;
    logic [31:0] a_val;
    logic        z_ack;
    logic        ack_s, ack_u;
    logic        stb_s, stb_u;
    logic [31:0] z_s, z_u;
    int          n_checks;
    int          n_fail;

    int_to_float #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst),
        .input_a_stb(a_stb), .input_a(a_val), .input_a_ack(ack_s),
        .output_z_stb(stb_s), .output_z_ack(z_ack), .output_z(z_s)
    );

    int_to_float #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst),
        .input_a_stb(a_stb), .input_a(a_val), .input_a_ack(ack_u),
        .output_z_stb(stb_u), .output_z_ack(z_ack), .output_z(z_u)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ack_s && ack_u) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("idle", {31'd0, ack_s && ack_u}, 32'd1);
    endtask

    task automatic run_conv(input string tag, input logic [31:0] a, input bit uns,
                            input logic [31:0] exp, input int exp_lat);
        int   cyc;
        logic got;
        wait_idle();
        a_stb = 1'b1;
        a_val = a;
        @(posedge clk); #1;
        a_stb = 1'b0;
        a_val = 32'hDEADBEEF;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            got = uns ? stb_u : stb_s;
        end
        check_eq({tag, "_stb"}, {31'd0, got}, 32'd1);
        check_eq({tag, "_z"}, uns ? z_u : z_s, exp);
        check_eq({tag, "_lat"}, cyc, exp_lat);
    endtask

    initial begin
        int   cyc;
        logic seen;
        clk = 1'b0; rst = 1'b0; a_stb = 1'b0; a_val = 32'd0; z_ack = 1'b1;
        n_checks = 0; n_fail = 0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("rst_ack", {31'd0, ack_s}, 32'd0);
            check_eq("rst_stb", {31'd0, stb_s}, 32'd0);
        end
        check_eq("rst_z", z_s, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("ack_after_rst", {31'd0, ack_s}, 32'd1);

        // Signed vectors
        run_conv("s_two",  32'h00000002, 1'b0, 32'h40000000, 34);
        run_conv("s_one",  32'h00000001, 1'b0, 32'h3F800000, 35);
        run_conv("s_m1",   32'hFFFFFFFF, 1'b0, 32'hBF800000, 35);
        run_conv("s_zero", 32'h00000000, 1'b0, 32'h00000000, 2);
        run_conv("s_min",  32'h80000000, 1'b0, 32'hCF000000, 4);
        run_conv("s_max",  32'h7FFFFFFF, 1'b0, 32'h4F000000, 5);
        run_conv("s_tie_even", 32'd16777217, 1'b0, 32'h4B800000, 11);
        run_conv("s_tie_up",   32'd16777219, 1'b0, 32'h4B800002, 11);
        run_conv("s_exact",    32'd16777218, 1'b0, 32'h4B800001, 11);

        // Unsigned vectors
        run_conv("u_max", 32'hFFFFFFFF, 1'b1, 32'h4F800000, 4);
        run_conv("u_top", 32'h80000000, 1'b1, 32'h4F000000, 4);
        run_conv("u_three", 32'h00000003, 1'b1, 32'h40400000, 34);

        // Backpressure then back-to-back transfer
        wait_idle();
        z_ack = 1'b0;
        a_stb = 1'b1;
        a_val = 32'd100;
        @(posedge clk); #1;
        a_val = 32'hFFFFFF9C;
        cyc = 0;
        while (!stb_s && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("bp_lat", cyc, 29);
        check_eq("bp_z", z_s, 32'h42C80000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_z", z_s, 32'h42C80000);
            check_eq("bp_hold_stb", {31'd0, stb_s}, 32'd1);
            check_eq("bp_hold_ack", {31'd0, ack_s}, 32'd0);
        end
        z_ack = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_stb_drop", {31'd0, stb_s}, 32'd0);
        check_eq("bp_ack_back", {31'd0, ack_s}, 32'd1);
        @(posedge clk); #1;
        a_stb = 1'b0;
        check_eq("b2b_ack_low", {31'd0, ack_s}, 32'd0);
        cyc = 0;
        while (!stb_s && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("b2b_lat", cyc, 29);
        check_eq("b2b_z", z_s, 32'hC2C80000);

        // Reset in the middle of a conversion
        wait_idle();
        a_stb = 1'b1;
        a_val = 32'd1;
        @(posedge clk); #1;
        a_stb = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("mid_rst_ack", {31'd0, ack_s}, 32'd0);
        check_eq("mid_rst_stb", {31'd0, stb_s}, 32'd0);
        check_eq("mid_rst_z", z_s, 32'd0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | stb_s;
        end
        rst = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | stb_s;
        end
        check_eq("mid_rst_no_result", {31'd0, seen}, 32'd0);
        run_conv("post_rst", 32'h00000040, 1'b0, 32'h42800000, 29);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_to_float.md
Name: int_to_float

Overview:
- Multi-cycle converter from a 32-bit integer to an IEEE-754 single-precision float.
- Counterpart of the FPU float_to_int unit; sits in the FPU next to it and services FCVT.S.W / FCVT.S.WU.
- Uses the same stb/ack handshake pair as the other FPU units: an input_a_stb/input_a_ack pair for the operand and an output_z_stb/output_z_ack pair for the result.
- Rounding mode is fixed at round-to-nearest-even.

Parameters:
SIGNED  1  1: input_a is two's complement (FCVT.S.W); 0: input_a is unsigned (FCVT.S.WU)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
input_a_stb  input  1  producer has a valid operand on input_a
input_a  input  32  integer operand
input_a_ack  output  1  unit ready to accept operand
output_z_stb  output  1  output_z holds a valid result
output_z_ack  input  1  consumer takes the result
output_z  output  32  IEEE-754 single result

Behaviour:
- Reset (rst=0, asynchronous): state=GET_A, input_a_ack=0, output_z_stb=0, output_z=0, internal regs=0. All outputs are registered.
- States: GET_A, CONVERT, NORMALISE, ROUND, PACK, PUT_Z.
- GET_A:
  - input_a_ack=1 on the first clock edge after rst releases, and stays 1 while in GET_A.
  - Transfer occurs on an edge where input_a_stb && input_a_ack. On that edge: capture input_a, drop input_a_ack to 0, go to CONVERT.
- CONVERT:
  - Sign: sign = SIGNED ? a[31] : 0.
  - Magnitude: m = sign ? -a : a, 32-bit unsigned; -2^31 gives m = 0x80000000 correctly.
  - Exponent: e = 31.
  - If m == 0: z = 0x00000000 (positive zero, never -0), go to PUT_Z. Otherwise go to NORMALISE.
- NORMALISE:
  - One bit per cycle: if m[31] == 0, shift m left by 1 and decrement e.
  - Otherwise go to ROUND.
  - Occupies lz+1 cycles, where lz = leading zeros of m (0..31).
- ROUND:
  - Fields: mant = m[31:8], guard = m[7], rnd = m[6], sticky = |m[5:0].
  - If guard && (rnd || sticky || mant[0]): mant = mant + 1.
  - If the increment carries out of 24 bits: mant = 0x800000, e = e + 1.
- PACK:
  - z = {sign, e+127 (8 bits), mant[22:0]}.
  - No overflow, denormal or NaN is possible; the maximum exponent is 32, giving 0x4F800000.
  - Go to PUT_Z.
- PUT_Z:
  - output_z_stb=1, and output_z is held stable while it is high.
  - On an edge with output_z_stb && output_z_ack: drop output_z_stb, set input_a_ack=1, return to GET_A.
  - output_z keeps its last value after the handshake.
- Latency, counted from the input transfer edge to the first edge where output_z_stb is seen high:
  - nonzero operand: lz+4 cycles (min 4, max 35);
  - zero operand: 2 cycles.
- Throughput: one conversion at a time. input_a_ack is 0 from the transfer edge until the output handshake completes. Back-to-back is allowed: if input_a_stb is held high, the next operand can transfer on the edge after returning to GET_A.
- Inputs outside the handshake windows are ignored:
  - output_z_ack while output_z_stb=0;
  - input_a_stb while input_a_ack=0.
  - input_a changes after the transfer edge do not affect the result.
- Reset mid-conversion: the conversion is aborted immediately, outputs return to their reset values, and no result is produced.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. Required: input_a_ack=0 and output_z_stb=0 during reset; input_a_ack=1 one edge after release.
- Basic (SIGNED=1), output_z_ack held 1:
  - input_a = 0x00000002 → 0x40000000
  - input_a = 1 → 0x3F800000, output_z_stb seen 35 cycles after the transfer edge
  - input_a = -1 (0xFFFFFFFF) → 0xBF800000
  - input_a = 0 → 0x00000000, output_z_stb seen 2 cycles after the transfer edge
- Extremes and rounding (SIGNED=1):
  - 0x80000000 → 0xCF000000, latency 4
  - 0x7FFFFFFF → 0x4F000000 (round-up exponent carry)
  - 16777217 → 0x4B800000 (tie, round to even)
  - 16777219 → 0x4B800002 (tie, round up)
  - 16777218 → 0x4B800001 (exact)
- Unsigned (SIGNED=0):
  - 0xFFFFFFFF → 0x4F800000
  - 0x80000000 → 0x4F000000
  - 3 → 0x40400000
- Output backpressure and back-to-back: hold output_z_ack=0 for 10 cycles after output_z_stb rises with input_a = 100.
  - Required while stalled: output_z stays 0x42C80000, output_z_stb stays 1, input_a_ack stays 0.
  - Pulse output_z_ack=1 for one cycle: output_z_stb falls on that edge.
  - With input_a_stb held high and input_a = -100, the next transfer occurs and produces 0xC2C80000.
- Reset mid-operation: transfer input_a = 1, then assert rst 5 cycles later.
  - Required: outputs return to their reset values immediately and output_z_stb never rises.
  - After release, input_a = 0x40 → 0x42800000.
